// File: rtl/xor_parity_accumulator_if.sv
// Purpose : stream bundle between a word producer, the XOR/parity accumulator and the result consumer.
// Latency : none (wires only).
// Backpressure: in_valid/in_ready on the word side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid / in_ready / in_data / in_last : word stream into the accumulator
//   odd_mode                                : parity sense, sampled on the first beat of a frame
//   out_valid / out_ready                   : result handshake
//   out_xor / out_parity / out_count / out_overflow : registered per-frame result
// Modports:
//   master : producer + consumer side (drives words and out_ready)
//   slave  : the accumulator block
interface xor_parity_accumulator_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16
);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             odd_mode;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_xor;
    logic             out_parity;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output odd_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_xor,
        input  out_parity,
        input  out_count,
        input  out_overflow
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  odd_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_xor,
        output out_parity,
        output out_count,
        output out_overflow
    );
endinterface

// File: rtl/xor_parity_accumulator.sv
// Purpose : per-frame lane-wise XOR checksum, parity bit and saturating word count over a valid/ready word stream.
// Latency : result valid the cycle after the last-beat accept; min frame period is N beats + 1 cycle.
// Backpressure: in_ready drops while a result is pending; result held stable until out_valid && out_ready.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : xor_parity_accumulator_if.slave
//          in_valid/in_ready/in_data/in_last/odd_mode in,
//          out_valid/out_ready/out_xor/out_parity/out_count/out_overflow out
module xor_parity_accumulator #(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    xor_parity_accumulator_if.slave     bus
);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Frame state
    state_e           state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             mode_q,      mode_d;
    logic             ovf_q,       ovf_d;

    // Handshake flops
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    // Result registers: kept separate from the accumulator so the last result
    // stays visible while the next frame is being accumulated.
    logic [WIDTH-1:0] res_xor_q,    res_xor_d;
    logic             res_parity_q, res_parity_d;
    logic [CNT_W-1:0] res_count_q,  res_count_d;
    logic             res_ovf_q,    res_ovf_d;

    logic             beat_acc;
    logic             res_take;

    // in_ready is registered and is 0 in DONE, so no beat is ever accepted there.
    assign beat_acc = bus.in_valid && in_ready_q;
    assign res_take = out_valid_q && bus.out_ready;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        ovf_d        = ovf_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        res_xor_d    = res_xor_q;
        res_parity_d = res_parity_q;
        res_count_d  = res_count_q;
        res_ovf_d    = res_ovf_q;

        case (state_q)
            IDLE: begin
                // Also covers the first edge after reset, where in_ready rises.
                in_ready_d = 1'b1;
                if (beat_acc) begin
                    acc_d   = bus.in_data;
                    cnt_d   = CNT_ONE;
                    mode_d  = bus.odd_mode;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end

            ACCUM: begin
                in_ready_d = 1'b1;
                if (beat_acc) begin
                    // Data keeps folding in after saturation; only the count stops.
                    acc_d = acc_q ^ bus.in_data;
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            DONE: begin
                in_ready_d = 1'b0;
                if (res_take) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase

        // Last beat: the same edge loads the result from the post-update
        // frame state, raises out_valid and closes the input.
        if (beat_acc && bus.in_last) begin
            state_d      = DONE;
            out_valid_d  = 1'b1;
            in_ready_d   = 1'b0;
            res_xor_d    = acc_d;
            res_parity_d = (^acc_d) ^ mode_d;
            res_count_d  = cnt_d;
            res_ovf_d    = ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            ovf_q        <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            res_xor_q    <= '0;
            res_parity_q <= 1'b0;
            res_count_q  <= '0;
            res_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            ovf_q        <= ovf_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            res_xor_q    <= res_xor_d;
            res_parity_q <= res_parity_d;
            res_count_q  <= res_count_d;
            res_ovf_q    <= res_ovf_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_xor      = res_xor_q;
    assign bus.out_parity   = res_parity_q;
    assign bus.out_count    = res_count_q;
    assign bus.out_overflow = res_ovf_q;

endmodule

// File: doc/xor_parity_accumulator.md
Name: xor_parity_accumulator

Overview:
- Parametrised, sequential successor to the team's single-bit XOR gate work.
- Accumulates a lane-wise XOR checksum and a single parity bit over a frame of WIDTH-bit words, delivered on a valid/ready stream.
- Presents one registered result per frame on an output valid/ready handshake.
- Sits between a word-stream producer and a checker/packetiser stage.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- MAX_WORDS, 16, word count at which the frame counter saturates and overflow is flagged (>=1).
- CNT_W, $clog2(MAX_WORDS+1), localparam, counter width. Not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word; registered.
- in_data  input  WIDTH  input word.
- in_last  input  1  qualifies the final word of a frame.
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled on the first beat of a frame only.
- out_valid  output  1  result valid; registered.
- out_ready  input  1  consumer accepts the result.
- out_xor  output  WIDTH  lane-wise XOR of all accepted words in the frame.
- out_parity  output  1  XOR-reduction of out_xor, inverted when the latched odd_mode = 1.
- out_count  output  CNT_W  words accepted in the frame, saturating at MAX_WORDS.
- out_overflow  output  1  frame exceeded MAX_WORDS words.

Behaviour:
- Reset is asynchronous and active-high; one clock. While rst = 1:
  - state = IDLE.
  - in_ready, out_valid, out_xor, out_parity, out_count and out_overflow are all 0.
  - The internal accumulator, counter and mode latch are 0.
- First rising edge after rst deasserts: in_ready goes to 1.
- Beat accept: in_valid && in_ready at a rising edge. in_data is ignored when the beat is not accepted.
- States:
  - IDLE: in_ready = 1. On accept:
    - acc <= in_data, cnt <= 1, mode <= odd_mode, ovf <= 0.
    - If in_last = 1, go to DONE; otherwise go to ACCUM.
  - ACCUM: in_ready = 1. On accept:
    - acc <= acc ^ in_data.
    - If cnt == MAX_WORDS: cnt holds and ovf <= 1 (sticky for the frame). Otherwise cnt <= cnt + 1.
    - If in_last = 1, go to DONE.
    - Idle cycles (in_valid = 0) hold all state, so gaps are allowed anywhere in a frame.
  - DONE: in_ready = 0, out_valid = 1.
    - out_xor, out_parity, out_count and out_overflow are driven from registers and held stable until the handshake.
    - On out_valid && out_ready, go to IDLE: out_valid <= 0 and in_ready <= 1 on that same edge.
- Registered transitions (no combinational paths):
  - The edge that accepts the last beat sets out_valid <= 1, loads the outputs, and clears in_ready <= 0.
- Latency and throughput:
  - out_valid is first high in the cycle immediately after the last-beat accept.
  - Minimum frame period is N beats + 1 cycle (one cycle in DONE with out_ready = 1).
  - in_valid is ignored during DONE.
- Output encoding:
  - out_parity = (^acc) ^ mode, so even mode gives total ones including parity even.
  - The outputs are not required to be 0 after the handshake; they hold the last result until the next load.
- Single-beat frames (in_last on the first beat) are legal. Zero-length frames do not exist.
- Overflow: data keeps XORing after saturation; only the count saturates.
- Reset mid-frame or mid-DONE: the partial frame and pending result are discarded and the block returns to reset values. No output handshake occurs for that frame.
- The producer must hold in_data, in_last and in_valid stable while in_valid = 1 and in_ready = 0 (standard valid/ready). The block never deasserts out_valid before the handshake completes.

Test Plan:
- WIDTH=8, MAX_WORDS=4 for all scenarios.
- Single beat: 0xA5, in_last=1, even mode -> next cycle out_valid=1, out_xor=0xA5, out_parity=0, out_count=1, out_overflow=0.
- Odd mode, 3 beats: 0x0F, 0xF0, 0xFF (last) -> out_xor=0x00, out_parity=1, out_count=3. Toggling odd_mode mid-frame has no effect.
- Overflow: six beats of 0x01, the sixth with last -> out_xor=0x00, out_count=4, out_overflow=1. The next frame (0x03, last) gives out_overflow=0, out_count=1, out_xor=0x03.
- Gaps and backpressure:
  - Frame 0x12, 3 idle cycles, then 0x34 (last), even mode -> out_xor=0x26, out_parity=1.
  - Hold out_ready=0 for 5 cycles: outputs stay stable, in_ready=0, and in_valid pulses are ignored.
  - After the handshake, the next cycle shows out_valid=0 and in_ready=1.
- Reset mid-frame: after 2 beats (0x11, 0x22), pulse rst asynchronously between edges -> all outputs 0 immediately and in_ready=0 during reset. A following frame 0x80 (last) gives out_xor=0x80, out_parity=1, out_count=1.
- Back-to-back: frame A = 0xFF (last) with out_ready=1 held high -> out_valid high for exactly 1 cycle. Frame B = 0x01 (last) is accepted on the following edge, and its result appears 1 cycle later.
